// File: rtl/sqrt_amp_dec.sv
// sqrt_amp_dec: decodes the quantiser's 16-bit square-root-spaced thermometer
// code into a 5-bit level and an 8-bit midpoint amplitude. It flags and counts
// bubbled codes and runs as a 2-stage valid/ready pipeline.
// Optional build macro: SQRT_AMP_DEC_PEAK_EN adds peak_clr / peak_amp, a
// running maximum of the transferred amplitudes.
module sqrt_amp_dec #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_ap,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_level,
   output logic [7:0]       out_amp,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt
`ifdef SQRT_AMP_DEC_PEAK_EN
   ,
   input  logic             peak_clr,
   output logic [7:0]       peak_amp
`endif
);

   // Midpoint of each square-root-spaced quantisation interval
   function automatic logic [7:0] amp_lut(input logic [4:0] lvl);
      case (lvl)
         5'd0:    amp_lut = 8'd0;
         5'd1:    amp_lut = 8'd2;
         5'd2:    amp_lut = 8'd5;
         5'd3:    amp_lut = 8'd10;
         5'd4:    amp_lut = 8'd17;
         5'd5:    amp_lut = 8'd26;
         5'd6:    amp_lut = 8'd37;
         5'd7:    amp_lut = 8'd50;
         5'd8:    amp_lut = 8'd66;
         5'd9:    amp_lut = 8'd83;
         5'd10:   amp_lut = 8'd101;
         5'd11:   amp_lut = 8'd122;
         5'd12:   amp_lut = 8'd145;
         5'd13:   amp_lut = 8'd170;
         5'd14:   amp_lut = 8'd192;
         5'd15:   amp_lut = 8'd221;
         default: amp_lut = 8'd248;
      endcase
   endfunction

   logic       s1_valid;
   logic [4:0] s1_level;
   logic       s1_err;
   logic       s2_free;
   logic       s1_free;
   logic       accept;
   logic       s2_load;
   logic [4:0] level_c;
   logic       malformed_c;

   assign s2_free  = !out_valid || out_ready;
   assign s1_free  = !s1_valid || s2_free;
   assign in_ready = s1_free;
   assign accept   = in_valid && in_ready;
   assign s2_load  = s1_valid && s2_free;

   // Level is the popcount; a 0 above a 1 anywhere marks a bubble
   always_comb begin
      level_c = 5'd0;
      for (int i = 0; i < 16; i++) level_c = level_c + {4'd0, in_ap[i]};
      malformed_c = |(~in_ap[15:1] & in_ap[14:0]);
   end

   // Stage 1: capture level and bubble flag of the accepted code
   always_ff @(posedge clock) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_level <= 5'd0;
         s1_err   <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_level <= level_c;
         s1_err   <= malformed_c;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: output register, held while downstream stalls
   always_ff @(posedge clock) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_level <= 5'd0;
         out_amp   <= 8'd0;
         out_err   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_level <= s1_level;
         out_amp   <= amp_lut(s1_level);
         out_err   <= s1_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Malformed-code counter, counted at input accept, saturating
   always_ff @(posedge clock) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (accept && malformed_c && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

`ifdef SQRT_AMP_DEC_PEAK_EN
   logic xfer;
   assign xfer = out_valid && out_ready;

   // Running peak of transferred amplitudes; a clear restarts from the
   // sample transferring in the same cycle, if any
   always_ff @(posedge clock) begin
      if (rst) begin
         peak_amp <= 8'd0;
      end else if (xfer) begin
         if (peak_clr || (out_amp > peak_amp)) peak_amp <= out_amp;
      end else if (peak_clr) begin
         peak_amp <= 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_sqrt_amp_dec.sv
// Bench for sqrt_amp_dec (CNT_W=4): scoreboard of expected decodes pushed on
// accept and popped on each output transfer, plus per-scenario checks.
module tb_sqrt_amp_dec;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_ap = 16'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_level;
   logic [7:0]  out_amp;
   logic        out_err;
   logic [3:0]  err_cnt;
`ifdef SQRT_AMP_DEC_PEAK_EN
   logic        peak_clr = 1'b0;
   logic [7:0]  peak_amp;
`endif

   sqrt_amp_dec #(.CNT_W(4)) dut (
      .clock(clock), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ap(in_ap),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_level(out_level), .out_amp(out_amp), .out_err(out_err),
      .err_cnt(err_cnt)
`ifdef SQRT_AMP_DEC_PEAK_EN
      , .peak_clr(peak_clr), .peak_amp(peak_amp)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0] level;
      logic [7:0] amp;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   exp_cnt = 0;
   logic [7:0] lut [17] = '{8'd0, 8'd2, 8'd5, 8'd10, 8'd17, 8'd26, 8'd37, 8'd50, 8'd66,
                            8'd83, 8'd101, 8'd122, 8'd145, 8'd170, 8'd192, 8'd221, 8'd248};

   // Expected decode: level = ones count, bubble = code differs from the
   // ideal thermometer word of that many ones
   function automatic void push(input logic [15:0] code);
      exp_t e;
      int pop;
      logic [31:0] thermo;
      pop = $countones(code);
      thermo = 32'h0000FFFF << (16 - pop);
      e.level = 5'(pop);
      e.amp   = lut[pop];
      e.err   = (code != thermo[15:0]);
      if (e.err && exp_cnt < 15) exp_cnt++;
      sb.push_back(e);
   endfunction

   // Scoreboard monitor: compare every output transfer in order
   always @(negedge clock) begin : mon
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL out_spurious: got level=%0d amp=%0d err=%0b, none expected",
                     out_level, out_amp, out_err);
         end else begin
            e = sb.pop_front();
            if ({out_level, out_amp, out_err} !== {e.level, e.amp, e.err})
               $display("FAIL out_sample: got level=%0d amp=%0d err=%0b, want level=%0d amp=%0d err=%0b",
                        out_level, out_amp, out_err, e.level, e.amp, e.err);
            else passes++;
         end
      end
   end

   // Drive one code and hold until accepted (called at posedge+1)
   task automatic send(input logic [15:0] code);
      int t;
      in_valid = 1'b1;
      in_ap = code;
      @(negedge clock);
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) begin
         checks++;
         $display("FAIL send_timeout: in_ready=%0b, want 1", in_ready);
      end else begin
         push(code);
      end
      @(posedge clock); #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(posedge clock); #1;
         t++;
      end
      checks++;
      if (sb.size() != 0) $display("FAIL drain_timeout: %0d samples outstanding, want 0", sb.size());
      else passes++;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clock);
      #1 rst = 1'b0;
      @(negedge clock);
      checks++;
      if ({out_valid, out_level, out_amp, out_err, err_cnt, in_ready} !== {1'b0, 5'd0, 8'd0, 1'b0, 4'd0, 1'b1})
         $display("FAIL reset_state: valid=%0b lvl=%0d amp=%0d err=%0b cnt=%0d rdy=%0b, want 0/0/0/0/0/1",
                  out_valid, out_level, out_amp, out_err, err_cnt, in_ready);
      else passes++;
`ifdef SQRT_AMP_DEC_PEAK_EN
      checks++;
      if (peak_amp !== 8'd0) $display("FAIL reset_peak: got %0d, want 0", peak_amp);
      else passes++;
`endif
      @(posedge clock); #1;
   endtask

   task automatic test_latency();
      out_ready = 1'b1;
      send(16'h8000);
      idle();
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL latency_early: out_valid=%0b, want 0", out_valid);
      else passes++;
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1) $display("FAIL latency_2cyc: out_valid=%0b, want 1", out_valid);
      else passes++;
      @(posedge clock); #1;
      drain();
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(16'h0000);
      send(16'hF000);
      send(16'hFFFF);
      idle();
      drain();
      checks++;
      if (err_cnt !== 4'd0) $display("FAIL basic_errcnt: got %0d, want 0", err_cnt);
      else passes++;
   endtask

   task automatic test_bubble();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_ap = 16'hE800;
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1 || err_cnt !== 4'd0)
         $display("FAIL bubble_pre: rdy=%0b cnt=%0d, want 1/0", in_ready, err_cnt);
      else passes++;
      push(16'hE800);
      @(posedge clock); #1;
      idle();
      @(negedge clock);
      checks++;
      if (err_cnt !== 4'd1) $display("FAIL bubble_errcnt: got %0d, want 1", err_cnt);
      else passes++;
      @(posedge clock); #1;
      drain();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      send(16'h8000);
      send(16'hC000);
      in_valid = 1'b1;
      in_ap = 16'hE000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_amp !== 8'd2)
            $display("FAIL stall_hold%0d: rdy=%0b valid=%0b amp=%0d, want 0/1/2",
                     k, in_ready, out_valid, out_amp);
         else passes++;
      end
      @(posedge clock); #1;
      out_ready = 1'b1;
      send(16'hE000);
      send(16'hF000);
      send(16'hF800);
      idle();
      drain();
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      send(16'h4000);
      send(16'h4000);
      idle();
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_cnt !== 4'(exp_cnt))
         $display("FAIL midrst_full: valid=%0b rdy=%0b cnt=%0d, want 1/0/%0d",
                  out_valid, in_ready, err_cnt, exp_cnt);
      else passes++;
      @(posedge clock); #1;
      rst = 1'b1;
      @(posedge clock); #1;
      rst = 1'b0;
      sb.delete();
      exp_cnt = 0;
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || err_cnt !== 4'd0)
         $display("FAIL midrst_clear: valid=%0b cnt=%0d, want 0/0", out_valid, err_cnt);
      else passes++;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         checks++;
         if (out_valid !== 1'b0) $display("FAIL midrst_stale%0d: out_valid=%0b, want 0", k, out_valid);
         else passes++;
      end
      @(posedge clock); #1;
   endtask

   task automatic test_saturate();
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) send(16'h4000);
      idle();
      drain();
      checks++;
      if (err_cnt !== 4'(exp_cnt) || err_cnt !== 4'd15)
         $display("FAIL sat_errcnt: got %0d, want 15", err_cnt);
      else passes++;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (err_cnt !== 4'd15) $display("FAIL sat_hold: got %0d, want 15", err_cnt);
      else passes++;
   endtask

`ifdef SQRT_AMP_DEC_PEAK_EN
   task automatic peak_step(input logic [15:0] code, input logic clr, input logic [7:0] want);
      int t;
      out_ready = 1'b1;
      send(code);
      idle();
      t = 0;
      @(negedge clock);
      while (!out_valid && t < 20) begin
         @(negedge clock);
         t++;
      end
      peak_clr = clr;
      @(posedge clock); #1;
      peak_clr = 1'b0;
      @(negedge clock);
      checks++;
      if (peak_amp !== want) $display("FAIL peak_amp: got %0d, want %0d", peak_amp, want);
      else passes++;
      @(posedge clock); #1;
   endtask

   task automatic test_peak();
      peak_step(16'hFE00, 1'b0, 8'd50);
      peak_step(16'hFFF0, 1'b0, 8'd145);
      peak_step(16'hF000, 1'b0, 8'd145);
      peak_step(16'hE000, 1'b1, 8'd10);
      drain();
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_basic();
      test_bubble();
      test_stall();
      test_reset_midstream();
      test_saturate();
`ifdef SQRT_AMP_DEC_PEAK_EN
      test_peak();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
